inst_cache: RTL
===============

// Module: inst_cache
// PURPOSE
//  - Direct-mapped, read-only instruction cache between the IF-stage PC (PCF) and the instruction memory.
//  - Returns the fetched word to the ID segment register.
//  - Raises miss to the hazard unit, which drives its ICacheMiss input; the hazard unit then stalls the pipeline.
//  - On a miss, refills one full line from instruction memory using a per-word request/valid handshake.
// PARAMETERS
//  LINE_ADDR_LEN  3   log2(words per line) -> 8 words/line
//  SET_ADDR_LEN   6   log2(number of lines) -> 64 lines
//  TAG_ADDR_LEN   32-SET_ADDR_LEN-LINE_ADDR_LEN-2 (derived localparam, not overridable)
// PORTS
//  CPU_CLK     in   1   clock, all state on posedge
//  CPU_RST     in   1   reset, asynchronous, active-high
//  rd_req      in   1   fetch request valid (core drives 1 except during reset)
//  addr        in   32  fetch byte address (PCF); bits [1:0] ignored
//  rd_data     out  32  instruction word, valid when rd_req & ~miss
//  miss        out  1   1 = data not available, core must stall IF/ID
//  flush       in   1   invalidate entire cache (fence.i), 1-cycle pulse
//  mem_req     out  1   memory word read request
//  mem_addr    out  32  word-aligned memory read address
//  mem_rvalid  in   1   memory returns mem_rdata this cycle
//  mem_rdata   in   32  memory read data
// BEHAVIOUR
//  - Reset:
//      - state=IDLE; all valid bits=0; word counter=0; pending-flush=0.
//      - rd_data=0; miss=0; mem_req=0; mem_addr=0.
//  - Address split: tag=addr[31:-], set=addr[SET+LINE+1:LINE+2], word=addr[LINE+1:2].
//  - Lookup:
//      - Combinational in IDLE: hit = rd_req & valid[set] & (tag_arr[set]==tag).
//      - Hit: miss=0; rd_data=data_arr[set][word] in the same cycle (zero-latency hit).
//  - rd_req=0: miss=0, rd_data=0, no refill started.
//  - States:
//      - IDLE: rd_req & ~hit -> miss=1, go REFILL, counter=0.
//      - REFILL:
//          - mem_req=1; mem_addr={tag,set,counter,2'b00}.
//          - On mem_rvalid: write mem_rdata to data_arr[set][counter], counter++.
//          - Counter wraps to 0 after the last word.
//          - Last word: write tag_arr, set valid[set], go DONE.
//          - mem_req may stay 1 back-to-back; each mem_rvalid consumes exactly one word.
//      - DONE: miss=1 for one cycle (array write settles), -> IDLE; next cycle hits.
//  - miss stays 1 from the first miss cycle through DONE inclusive.
//  - Miss penalty = 8 handshakes + 2 cycles minimum.
//  - addr must stay stable while miss=1; the cache latches set/tag at miss entry and ignores later addr changes until IDLE.
//  - Flush:
//      - In IDLE: all valid bits cleared at the next edge.
//      - In REFILL/DONE: recorded in pending-flush; the refill completes, then all valid bits (including the new line) are cleared on entry to IDLE.
//      - flush in the same cycle as a lookup miss: the flush wins, the refill still starts.
//  - Reset mid-refill: immediate return to IDLE, mem_req=0, no line validated; any late mem_rvalid is ignored.
//  - Data/tag arrays are not reset; only valid bits are.
// CONFIGURATION
//  - ICACHE_STATS_EN defined:
//      - Adds 32-bit output counters hit_cnt and miss_cnt.
//      - Each increments once per IDLE-cycle lookup with rd_req=1 (hit or first miss cycle).
//      - Reset clears both; the counters saturate at 32'hFFFF_FFFF.
//  - ICACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package icache_pkg:
//      - state encoding IDLE=2'd0, REFILL=2'd1, DONE=2'd2.
//      - default LINE/SET widths.
//  - One sub-module: icache_refill_fsm
//      - Owns state, counter, pending-flush, mem_req/mem_addr.
//      - Top keeps the arrays and lookup.
// TESTING
//  - Reset, then rd_req=1 addr=0x0000_0000 -> miss=1, mem_addr 0x00..0x1C in order; after 8 rvalids + DONE -> miss=0, rd_data=mem[0].
//  - addr=0x0000_0014 right after that fill -> hit, miss=0 in the same cycle, rd_data=mem[5], mem_req=0.
//  - Conflict: fill 0x0000_0000, then fetch 0x0000_0800 (same set, new tag) -> miss, refill; refetch 0x0 -> misses again.
//  - mem_rvalid with random gaps of 0-5 cycles -> data_arr contents correct; miss held 1 throughout; exactly 8 words consumed.
//  - flush pulse during REFILL word 3 -> refill completes; following fetch of the same addr misses again.
//  - CPU_RST asserted after 4 refill words -> mem_req=0 immediately; after release, fetch of the same addr misses (line not valid).

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: refill FSM state encoding
// and the default line/set geometry.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int LINE_ADDR_LEN_DEF = 3;
  localparam int SET_ADDR_LEN_DEF  = 6;

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer for inst_cache.
// Owns the FSM state, the word counter, the deferred-flush flag and the
// memory request/address. It latches set/tag when a miss is taken, so later
// changes on the fetch address do not affect an ongoing refill.
//
// state  | meaning
// IDLE   | lookups served; a miss starts a refill
// REFILL | one word per mem_rvalid, counter selects the word
// DONE   | line written, one settling cycle before lookups resume
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
  parameter int TAG_ADDR_LEN  = 32 - SET_ADDR_LEN - LINE_ADDR_LEN - 2
) (
  input  logic                     CPU_CLK,
  input  logic                     CPU_RST,
  input  logic                     lookup_miss_i,
  input  logic                     flush_i,
  input  logic [SET_ADDR_LEN-1:0]  set_i,
  input  logic [TAG_ADDR_LEN-1:0]  tag_i,
  input  logic                     mem_rvalid_i,
  output state_e                   state_o,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  output logic                     wr_en_o,
  output logic                     line_done_o,
  output logic                     clear_all_o,
  output logic [SET_ADDR_LEN-1:0]  wr_set_o,
  output logic [TAG_ADDR_LEN-1:0]  wr_tag_o,
  output logic [LINE_ADDR_LEN-1:0] wr_word_o
);

  state_e                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
  logic [SET_ADDR_LEN-1:0]  set_q, set_d;
  logic [TAG_ADDR_LEN-1:0]  tag_q, tag_d;
  logic                     pend_q, pend_d;

  // State register; reset abandons any refill in progress.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      set_q   <= '0;
      tag_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and array-update strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    set_d       = set_q;
    tag_d       = tag_q;
    pend_d      = pend_q;
    wr_en_o     = 1'b0;
    line_done_o = 1'b0;
    clear_all_o = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush here clears immediately, even if a refill starts this cycle.
        clear_all_o = flush_i;
        if (lookup_miss_i) begin
          state_d = REFILL;
          cnt_d   = '0;
          set_d   = set_i;
          tag_d   = tag_i;
        end
      end
      REFILL: begin
        if (flush_i) pend_d = 1'b1;
        if (mem_rvalid_i) begin
          wr_en_o = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            line_done_o = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        // A deferred flush also wipes the line that was just validated.
        clear_all_o = pend_q | flush_i;
        pend_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign mem_req_o  = (state_q == REFILL);
  assign mem_addr_o = mem_req_o ? {tag_q, set_q, cnt_q, 2'b00} : 32'd0;
  assign wr_set_o   = set_q;
  assign wr_tag_o   = tag_q;
  assign wr_word_o  = cnt_q;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with zero-latency hits and
// word-by-word line refill. Optional hit/miss counters when ICACHE_STATS_EN
// is defined.
module inst_cache
  import icache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        rd_req,
  input  logic [31:0] addr,
  output logic [31:0] rd_data,
  output logic        miss,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_ADDR_LEN = 32 - SET_ADDR_LEN - LINE_ADDR_LEN - 2;
  localparam int NUM_SETS     = 1 << SET_ADDR_LEN;
  localparam int NUM_WORDS    = 1 << LINE_ADDR_LEN;

  logic [TAG_ADDR_LEN-1:0]  lk_tag;
  logic [SET_ADDR_LEN-1:0]  lk_set;
  logic [LINE_ADDR_LEN-1:0] lk_word;
  logic                     unused_addr_bits;

  logic [31:0]             data_arr [NUM_SETS][NUM_WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_arr  [NUM_SETS];
  logic [NUM_SETS-1:0]     valid_q;

  state_e                   state;
  logic                     hit, lookup_miss;
  logic                     wr_en, line_done, clear_all;
  logic [SET_ADDR_LEN-1:0]  wr_set;
  logic [TAG_ADDR_LEN-1:0]  wr_tag;
  logic [LINE_ADDR_LEN-1:0] wr_word;

  assign lk_tag           = addr[31 -: TAG_ADDR_LEN];
  assign lk_set           = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1 : LINE_ADDR_LEN+2];
  assign lk_word          = addr[LINE_ADDR_LEN+1 : 2];
  assign unused_addr_bits = ^addr[1:0];

  assign hit         = (state == IDLE) & rd_req & valid_q[lk_set] & (tag_arr[lk_set] == lk_tag);
  assign lookup_miss = (state == IDLE) & rd_req & ~hit;
  assign miss        = (state == IDLE) ? lookup_miss : 1'b1;
  assign rd_data     = hit ? data_arr[lk_set][lk_word] : 32'd0;

  icache_refill_fsm #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .SET_ADDR_LEN  (SET_ADDR_LEN),
    .TAG_ADDR_LEN  (TAG_ADDR_LEN)
  ) u_refill (
    .CPU_CLK       (CPU_CLK),
    .CPU_RST       (CPU_RST),
    .lookup_miss_i (lookup_miss),
    .flush_i       (flush),
    .set_i         (lk_set),
    .tag_i         (lk_tag),
    .mem_rvalid_i  (mem_rvalid),
    .state_o       (state),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .wr_en_o       (wr_en),
    .line_done_o   (line_done),
    .clear_all_o   (clear_all),
    .wr_set_o      (wr_set),
    .wr_tag_o      (wr_tag),
    .wr_word_o     (wr_word)
  );

  // Valid bits: flush clears everything, the last refill word validates its line.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST)        valid_q <= '0;
    else if (clear_all) valid_q <= '0;
    else if (line_done) valid_q[wr_set] <= 1'b1;
  end

  // Data and tag storage; not reset, guarded by the valid bits.
  always_ff @(posedge CPU_CLK) begin
    if (wr_en)     data_arr[wr_set][wr_word] <= mem_rdata;
    if (line_done) tag_arr[wr_set] <= wr_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup counters, one event per IDLE cycle with a request.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if ((state == IDLE) && rd_req) begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF))          hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit && (miss_cnt_q != 32'hFFFF_FFFF))        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
